// File: rtl/dff_chk_pkg.sv
// rtl/dff_chk_pkg.sv - shared state type, stimulus windows and stimulus helpers for the DFF checker
package dff_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

    localparam int CNT_W = 8;

    localparam logic [CNT_W-1:0] RST_LO   = 8'd10;
    localparam logic [CNT_W-1:0] RST_HI   = 8'd19;
    localparam logic [CNT_W-1:0] PRE_LO   = 8'd15;
    localparam logic [CNT_W-1:0] PRE_HI   = 8'd24;
    localparam logic [CNT_W-1:0] INIT_CYC = 8'd2;

    // The first INIT_CYC cycles hold the DUT in reset so it starts from a known 0.
    function automatic logic stim_reset_n(input logic [CNT_W-1:0] c);
        return !((c < INIT_CYC) || ((c >= RST_LO) && (c <= RST_HI)));
    endfunction

    function automatic logic stim_preset_n(input logic [CNT_W-1:0] c);
        return !((c >= PRE_LO) && (c <= PRE_HI));
    endfunction

endpackage

// File: rtl/dff_chk_if.sv
// rtl/dff_chk_if.sv - control and DUT-facing signals of the DFF stimulus checker
interface dff_chk_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic             dut_d;
    logic             dut_reset;
    logic             dut_preset;
    logic             dut_q;
    logic             dut_qn;

    modport master (
        input  start, dut_q, dut_qn,
        output busy, done, pass, err_count, dut_d, dut_reset, dut_preset
    );

    modport slave (
        output start, dut_q, dut_qn,
        input  busy, done, pass, err_count, dut_d, dut_reset, dut_preset
    );
endinterface

// File: rtl/dff_ref_model.sv
// rtl/dff_ref_model.sv - expected Q of an ideal async-reset/preset DFF under the driven stimulus
module dff_ref_model (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic dut_d,
    input  logic dut_reset,
    input  logic dut_preset,
    output logic q_exp
);
    logic m;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            m <= 1'b0;
        end else if (en) begin
            if (!dut_reset) begin
                m <= 1'b0;
            end else if (!dut_preset) begin
                m <= 1'b1;
            end else begin
                m <= dut_d;
            end
        end
    end

    // Async controls override the stored value; reset wins over preset.
    always_comb begin
        q_exp = m;
        if (!dut_reset) begin
            q_exp = 1'b0;
        end else if (!dut_preset) begin
            q_exp = 1'b1;
        end
    end
endmodule

// File: rtl/dff_stim_checker.sv
// rtl/dff_stim_checker.sv - drives a fixed D/reset/preset pattern into a DFF and counts Q/QN mismatches
module dff_stim_checker
    import dff_chk_pkg::*;
#(
    parameter int CYCLES = 64,
    parameter int ERR_W  = 8
) (
    input logic       clock,
    input logic       reset,
    dff_chk_if.master bus
);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    chk_state_e       state_q;
    chk_state_e       state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [ERR_W-1:0] err_q;
    logic             run_start;
    logic             in_run;
    logic             last;
    logic             q_exp;
    logic             mismatch;
    logic             d_q;
    logic             rst_n_q;
    logic             pre_n_q;

    assign in_run   = (state_q == RUN);
    assign cnt_nxt  = run_start ? '0 : cnt + 1'b1;
    assign mismatch = (bus.dut_q != q_exp) || (bus.dut_qn != ~q_exp);

    always_comb begin
        state_d   = state_q;
        run_start = 1'b0;
        last      = (cnt == LAST);
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = RUN;
                    run_start = 1'b1;
                end
            end
            RUN: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt     <= '0;
            err_q   <= '0;
            d_q     <= 1'b0;
            rst_n_q <= 1'b1;
            pre_n_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (run_start) begin
                cnt   <= '0;
                err_q <= '0;
            end else if (in_run) begin
                if (!last) begin
                    cnt <= cnt + 1'b1;
                end
                if (mismatch && (cnt >= INIT_CYC) && (err_q != ERR_MAX)) begin
                    err_q <= err_q + 1'b1;
                end
            end
            // Stimulus is computed from the upcoming count so the pins track cnt.
            if (run_start || (in_run && !last)) begin
                d_q     <= cnt_nxt[0];
                rst_n_q <= stim_reset_n(cnt_nxt);
                pre_n_q <= stim_preset_n(cnt_nxt);
            end else if (in_run) begin
                d_q     <= 1'b0;
                rst_n_q <= 1'b1;
                pre_n_q <= 1'b1;
            end
        end
    end

    dff_ref_model u_ref (
        .clock      (clock),
        .reset      (reset),
        .clear      (run_start),
        .en         (in_run),
        .dut_d      (d_q),
        .dut_reset  (rst_n_q),
        .dut_preset (pre_n_q),
        .q_exp      (q_exp)
    );

    assign bus.dut_d      = d_q;
    assign bus.dut_reset  = rst_n_q;
    assign bus.dut_preset = pre_n_q;
    assign bus.busy       = in_run;
    assign bus.done       = (state_q == DONE);
    assign bus.pass       = (state_q == DONE) && (err_q == '0);
    assign bus.err_count  = err_q;
endmodule
